gshare_predictor: RTL

Parametrised gshare direction predictor for the MIPS core. The prediction table is indexed by word-aligned PC XOR global history. The global history register (GHR) is updated speculatively at predict time and repaired on mispredict feedback. The block sits behind branch_controller: requests come from decode, feedback comes from execute. An init state machine clears the table after reset.

---
 rtl/gshare_predictor_if.sv | 40 ++++
 rtl/gshare_predictor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor_if.sv
// Request/feedback bundle between branch_controller and the gshare predictor.
// Latency: none; this only groups wires.
// Backpressure: none; o_ready low means requests and feedback are ignored.
//
// Branch outcome encoding on the *_prediction / *_outcome wires:
//   1'b1 = TAKEN, 1'b0 = NOT_TAKEN.
//
// Modports:
//   master - decode/execute side: drives requests and feedback, sees prediction
//   slave  - predictor side
interface gshare_predictor_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int HIST_WIDTH = 10
);
  // request from decode
  logic                  i_req_valid;
  logic [ADDR_WIDTH-1:0] i_req_pc;
  logic                  o_req_prediction;
  logic [HIST_WIDTH-1:0] o_req_history;
  logic                  o_ready;

  // feedback from execute
  logic                  i_fb_valid;
  logic [ADDR_WIDTH-1:0] i_fb_pc;
  logic [HIST_WIDTH-1:0] i_fb_history;
  logic                  i_fb_prediction;
  logic                  i_fb_outcome;

  modport master (
    output i_req_valid, i_req_pc,
    output i_fb_valid, i_fb_pc, i_fb_history, i_fb_prediction, i_fb_outcome,
    input  o_req_prediction, o_req_history, o_ready
  );

  modport slave (
    input  i_req_valid, i_req_pc,
    input  i_fb_valid, i_fb_pc, i_fb_history, i_fb_prediction, i_fb_outcome,
    output o_req_prediction, o_req_history, o_ready
  );
endinterface

// File: rtl/gshare_predictor.sv
// gshare direction predictor: table of saturating counters indexed by PC ^ GHR.
// Latency: prediction is combinational from current state; updates land next cycle.
// Backpressure: none; o_ready is low while the table is swept after reset.
//
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset; restarts the table sweep
//   bus    - gshare_predictor_if.slave: request (valid, pc -> prediction,
//            history), feedback (valid, pc, history, prediction, outcome),
//            o_ready
//
// Optional build macro GSHARE_BYPASS_EN: forwards a same-cycle feedback update
// to a request hitting the same index. Table contents are identical either way.
module gshare_predictor #(
  parameter int ADDR_WIDTH  = 26,
  parameter int INDEX_WIDTH = 10,
  parameter int HIST_WIDTH  = 10,
  parameter int CTR_WIDTH   = 2
) (
  input logic                clk,
  input logic                rst_n,
  gshare_predictor_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Parameter sanity
  // ---------------------------------------------------------------------------
  if (HIST_WIDTH > INDEX_WIDTH || HIST_WIDTH < 1) begin : g_bad_hist
    $error("gshare_predictor: HIST_WIDTH must be in 1..INDEX_WIDTH");
  end
  if (CTR_WIDTH < 1) begin : g_bad_ctr
    $error("gshare_predictor: CTR_WIDTH must be >= 1");
  end
  if (ADDR_WIDTH < INDEX_WIDTH + 2) begin : g_bad_addr
    $error("gshare_predictor: ADDR_WIDTH too small for INDEX_WIDTH");
  end

  localparam int DEPTH = 1 << INDEX_WIDTH;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  localparam logic [CTR_WIDTH-1:0]   CTR_MAX  = '1;
  // Weakly not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
  localparam logic [CTR_WIDTH-1:0]   CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [INDEX_WIDTH-1:0] PTR_LAST = INDEX_WIDTH'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [INDEX_WIDTH-1:0] ptr_q;
  logic [HIST_WIDTH-1:0]  ghr_q;
  logic [CTR_WIDTH-1:0]   ctr_tbl [DEPTH];

  // FSM outputs
  logic run;
  logic sweep_en;

  // ---------------------------------------------------------------------------
  // Counter step toward an outcome, saturating at both ends
  // ---------------------------------------------------------------------------
  function automatic logic [CTR_WIDTH-1:0] ctr_step(input logic [CTR_WIDTH-1:0] c,
                                                    input logic                 up);
    if (up) begin
      return (c == CTR_MAX) ? c : c + CTR_WIDTH'(1);
    end
    return (c == '0) ? c : c - CTR_WIDTH'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Indexing: word-aligned PC bits XOR history placed in the low bits
  // ---------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [INDEX_WIDTH-1:0] fb_idx;

  assign req_idx = bus.i_req_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_q);
  assign fb_idx  = bus.i_fb_pc[INDEX_WIDTH+1:2]  ^ INDEX_WIDTH'(bus.i_fb_history);

  logic [CTR_WIDTH-1:0] req_ctr;
  logic [CTR_WIDTH-1:0] fb_ctr;
  logic [CTR_WIDTH-1:0] fb_ctr_next;

  assign req_ctr     = ctr_tbl[req_idx];
  assign fb_ctr      = ctr_tbl[fb_idx];
  assign fb_ctr_next = ctr_step(fb_ctr, bus.i_fb_outcome == TAKEN);

  // Only the index slice of each PC feeds the table; the rest is ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.i_req_pc, bus.i_fb_pc};

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (ptr_q == PTR_LAST) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    run      = 1'b0;
    sweep_en = 1'b0;
    case (state_q)
      ST_INIT: sweep_en = 1'b1;
      ST_RUN:  run      = 1'b1;
      default: sweep_en = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sweep pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (sweep_en) begin
      ptr_q <= ptr_q + INDEX_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Table write port: sweep during INIT, feedback update during RUN.
  // The table has no reset of its own; the sweep is what clears it.
  // ---------------------------------------------------------------------------
  logic                   tbl_we;
  logic [INDEX_WIDTH-1:0] tbl_waddr;
  logic [CTR_WIDTH-1:0]   tbl_wdata;

  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = fb_idx;
    tbl_wdata = fb_ctr_next;
    if (sweep_en) begin
      tbl_we    = 1'b1;
      tbl_waddr = ptr_q;
      tbl_wdata = CTR_INIT;
    end else if (run && bus.i_fb_valid) begin
      tbl_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      ctr_tbl[tbl_waddr] <= tbl_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Prediction
  // ---------------------------------------------------------------------------
  logic pred_bit;

  always_comb begin
    pred_bit = req_ctr[CTR_WIDTH-1];
`ifdef GSHARE_BYPASS_EN
    // Forward the counter being written this cycle to a colliding read.
    if (bus.i_fb_valid && (fb_idx == req_idx)) begin
      pred_bit = fb_ctr_next[CTR_WIDTH-1];
    end
`endif
    if (!run) begin
      pred_bit = NOT_TAKEN;
    end
  end

  assign bus.o_req_prediction = pred_bit;
  assign bus.o_req_history    = run ? ghr_q : '0;
  assign bus.o_ready          = run;

  // ---------------------------------------------------------------------------
  // Global history: speculative shift on request, repair on mispredict.
  // A 1-bit history just holds the latest outcome.
  // ---------------------------------------------------------------------------
  logic [HIST_WIDTH-1:0] ghr_spec;
  logic [HIST_WIDTH-1:0] ghr_repair;

  if (HIST_WIDTH == 1) begin : g_hist1
    assign ghr_spec   = pred_bit;
    assign ghr_repair = bus.i_fb_outcome;
  end else begin : g_histn
    assign ghr_spec   = {ghr_q[HIST_WIDTH-2:0], pred_bit};
    assign ghr_repair = {bus.i_fb_history[HIST_WIDTH-2:0], bus.i_fb_outcome};
  end

  logic mispredict;
  assign mispredict = bus.i_fb_valid && (bus.i_fb_prediction != bus.i_fb_outcome);

  // Repair outranks a same-cycle request: that request is flushed upstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (run) begin
      if (mispredict) begin
        ghr_q <= ghr_repair;
      end else if (bus.i_req_valid) begin
        ghr_q <= ghr_spec;
      end
    end
  end

endmodule
